// File: rtl/sort_pkg.sv
// Shared types for the sort-engine packet arbiter: FSM state encoding and index-width helpers.
package sort_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } sort_arb_state_t;

    localparam int N_SRC_DEFAULT = 4;
    localparam int SRC_IDX_W     = $clog2(N_SRC_DEFAULT);

    function automatic int src_idx_w(input int n_src);
        return (n_src > 1) ? $clog2(n_src) : 1;
    endfunction

endpackage

// File: rtl/sort_pkt_arbiter_rr_select.sv
// Round-robin pick: rotate requests so the slot after last_grant is bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module rr_select
    import sort_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int IDX_W = src_idx_w(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic             found,
    output logic [IDX_W-1:0] next_grant
);

    logic [N_SRC-1:0] rotated;
    logic [IDX_W-1:0] src_idx;
    logic [IDX_W-1:0] pick;

    always_comb begin
        rotated = '0;
        src_idx = '0;
        for (int j = 0; j < N_SRC; j++) begin
            src_idx    = IDX_W'((int'(last_grant) + 1 + j) % N_SRC);
            rotated[j] = req[src_idx];
        end

        found = 1'b0;
        pick  = '0;
        for (int j = N_SRC - 1; j >= 0; j--) begin
            if (rotated[j]) begin
                found = 1'b1;
                pick  = IDX_W'(j);
            end
        end

        next_grant = IDX_W'((int'(last_grant) + 1 + int'(pick)) % N_SRC);
    end

endmodule

// File: rtl/sort_pkt_arbiter.sv
// Packet-level round-robin arbiter in front of the sort engine sink port.
// Define SORT_ARB_LEN_GUARD_EN to truncate packets at MAX_PKT_LEN words and drop the excess.
module sort_pkt_arbiter
    import sort_pkg::*;
#(
    parameter int N_SRC       = 4,
    parameter int DWIDTH      = 8,
    parameter int MAX_PKT_LEN = 1024
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic [N_SRC*DWIDTH-1:0]     snk_data_i,
    input  logic [N_SRC-1:0]            snk_startofpacket_i,
    input  logic [N_SRC-1:0]            snk_endofpacket_i,
    input  logic [N_SRC-1:0]            snk_valid_i,
    output logic [N_SRC-1:0]            snk_ready_o,
    output logic [DWIDTH-1:0]           src_data_o,
    output logic                        src_startofpacket_o,
    output logic                        src_endofpacket_o,
    output logic                        src_valid_o,
    input  logic                        src_ready_i,
    output logic [src_idx_w(N_SRC)-1:0] src_channel_o
);

    localparam int IDX_W = src_idx_w(N_SRC);

    if (N_SRC < 2 || MAX_PKT_LEN < 1) begin : g_bad_cfg
        $error("sort_pkt_arbiter: N_SRC must be >= 2 and MAX_PKT_LEN >= 1");
    end

    sort_arb_state_t  state;
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] last_grant;
    logic [IDX_W-1:0] next_grant;
    logic             found;
    logic [N_SRC-1:0] req;

    logic [DWIDTH-1:0] g_data;
    logic              g_valid;
    logic              g_sop;
    logic              g_eop;
    logic              force_eop;
    logic              pass_hs;

    assign req = snk_valid_i & snk_startofpacket_i;

    rr_select #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req        (req),
        .last_grant (last_grant),
        .found      (found),
        .next_grant (next_grant)
    );

    always_comb begin
        g_data  = '0;
        g_valid = 1'b0;
        g_sop   = 1'b0;
        g_eop   = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant == IDX_W'(i)) begin
                g_data  = snk_data_i[i*DWIDTH +: DWIDTH];
                g_valid = snk_valid_i[i];
                g_sop   = snk_startofpacket_i[i];
                g_eop   = snk_endofpacket_i[i];
            end
        end
    end

    assign pass_hs = (state == PASS) && g_valid && src_ready_i;

`ifdef SORT_ARB_LEN_GUARD_EN
    localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);

    logic [CNT_W-1:0] word_cnt;

    // Counts words already handshaken, so the MAX_PKT_LEN-th word sees MAX_PKT_LEN-1.
    assign force_eop = (state == PASS) && (word_cnt == CNT_W'(MAX_PKT_LEN - 1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            word_cnt <= '0;
        end else if (state != PASS) begin
            word_cnt <= '0;
        end else if (pass_hs) begin
            word_cnt <= word_cnt + CNT_W'(1);
        end
    end
`else
    assign force_eop = 1'b0;
`endif

    // Outputs are gated by rstn_i so they fall as soon as reset asserts.
    always_comb begin
        src_valid_o         = 1'b0;
        src_startofpacket_o = 1'b0;
        src_endofpacket_o   = 1'b0;
        src_data_o          = g_data;
        snk_ready_o         = '0;
        if (rstn_i) begin
            case (state)
                IDLE: begin
                    snk_ready_o = snk_valid_i & ~snk_startofpacket_i;
                end
                PASS: begin
                    src_valid_o         = g_valid;
                    src_startofpacket_o = g_sop;
                    src_endofpacket_o   = g_eop | force_eop;
                    for (int i = 0; i < N_SRC; i++) begin
                        if (grant == IDX_W'(i)) snk_ready_o[i] = src_ready_i;
                    end
                end
                DROP: begin
                    for (int i = 0; i < N_SRC; i++) begin
                        if (grant == IDX_W'(i)) snk_ready_o[i] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IDX_W'(N_SRC - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant <= next_grant;
                        state <= PASS;
                    end
                end
                PASS: begin
                    if (pass_hs && g_eop) begin
                        last_grant <= grant;
                        state      <= IDLE;
                    end
`ifdef SORT_ARB_LEN_GUARD_EN
                    else if (pass_hs && force_eop) begin
                        last_grant <= grant;
                        state      <= DROP;
                    end
`endif
                end
`ifdef SORT_ARB_LEN_GUARD_EN
                DROP: begin
                    if (g_valid && g_eop) state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign src_channel_o = grant;

endmodule

// File: doc/sort_pkt_arbiter.md
# sort_pkt_arbiter

Packet-level round-robin arbiter sharing one `sort` engine between `N_SRC` Avalon-ST producers. It sits directly in front of the sort engine's sink port. It grants one source per packet and holds the grant until that packet's end-of-packet handshake. The data path is forwarded combinationally while a grant is held. Stray words outside a packet are discarded, and an optional length guard protects the engine's `MAX_PKT_LEN` buffer.

## Interface
- `N_SRC`, default 4: number of requesting sources, ≥2
- `DWIDTH`, default 8: data word width
- `MAX_PKT_LEN`, default 1024: engine buffer depth in words; used only by the length guard
- `clk_i`  in  1  clock; all state on rising edge
- `rstn_i`  in  1  reset; asynchronous, active-low
- `snk_data_i`  in  N_SRC*DWIDTH  source i occupies bits [i*DWIDTH +: DWIDTH]
- `snk_startofpacket_i`  in  N_SRC  per-source SOP
- `snk_endofpacket_i`  in  N_SRC  per-source EOP
- `snk_valid_i`  in  N_SRC  per-source valid
- `snk_ready_o`  out  N_SRC  per-source ready
- `src_data_o`  out  DWIDTH  data to sort engine
- `src_startofpacket_o`  out  1  SOP to engine
- `src_endofpacket_o`  out  1  EOP to engine (may be forced by the length guard)
- `src_valid_o`  out  1  valid to engine
- `src_ready_i`  in  1  engine ready
- `src_channel_o`  out  $clog2(N_SRC)  index of the granted source, stable for the whole packet

## Operation
- Handshake: a word transfers when valid && ready are both high on a rising edge.
- Request for source i: `snk_valid_i[i] && snk_startofpacket_i[i]`.
- States:
  - **IDLE**: `src_valid_o`=0. For any source with valid && !sop, `snk_ready_o[i]`=1 and the word is discarded (stray flush). Requesting sources see `snk_ready_o`=0. If any request is present, select the first requester strictly after `last_grant`, cyclically. Register it as `grant` and go to PASS.
  - **PASS**: `src_data_o`/`sop`/`eop`/`valid` = source `grant`'s signals. `snk_ready_o[grant]` = `src_ready_i`. All other `snk_ready_o` = 0. On a handshake with EOP: `last_grant` <= `grant`, go to IDLE.
  - **DROP** (only with the length guard): `src_valid_o`=0. `snk_ready_o[grant]`=1 and all words are discarded. On a handshake with EOP, go to IDLE.
- `src_channel_o` = `grant`, registered. It holds its value in IDLE.
- Single-word packets (SOP && EOP): PASS lasts until that one word handshakes, then returns to IDLE.
- SOP arriving mid-packet on the granted source: forwarded unchanged. The engine owns framing errors.

## Timing
- Reset values: state=IDLE, `grant`=0, `last_grant`=N_SRC-1 (source 0 wins first), `src_channel_o`=0, word counter=0.
- Reset output values: `src_valid_o`, `src_startofpacket_o`, `src_endofpacket_o` and `snk_ready_o` all 0. `src_data_o` is don't-care.
- Reset asserted mid-packet: the block returns to IDLE immediately and all outputs drop asynchronously. The partial packet is lost and is not replayed.
- Arbitration latency: a request seen in IDLE at edge k gives PASS with the first word forwardable in cycle k+1. There is exactly one bubble cycle between back-to-back packets.
- In PASS the data/control path is combinational, with zero added latency. `src_ready_i` stalls propagate in the same cycle.
- Requests arriving during PASS wait; none are dropped. Simultaneous requests resolve by the round-robin order.

## Configuration
- `SORT_ARB_LEN_GUARD_EN` **defined**:
  - A $clog2(MAX_PKT_LEN+1)-bit counter counts handshaken words in PASS and clears in IDLE.
  - On the MAX_PKT_LEN-th word, if it has no EOP, `src_endofpacket_o` is forced to 1. After that handshake, go to DROP.
  - If the input EOP coincides with that word, go to IDLE and skip DROP.
- `SORT_ARB_LEN_GUARD_EN` **undefined**: no counter and no DROP state. Packets of any length pass through unmodified.

## Structure
- Package `sort_pkg` holds:
  - the state enum `sort_arb_state_t` (IDLE, PASS, DROP);
  - localparam helper `SRC_IDX_W = $clog2(N_SRC)`.
- Sub-module `rr_select`: combinational request vector plus `last_grant`, producing `found` and `next_grant`. Implemented as a rotate, priority-encode and un-rotate.

## Test plan
- **Basic pass**: source 2 sends a 4-word packet 0x05,0x03,0x09,0x01 with `src_ready_i`=1 → grant asserted one cycle after the request; `src_channel_o`=2; output words identical, with SOP on the first word and EOP on the last; back to IDLE.
- **Round-robin**: sources 0, 1 and 3 all request continuously with 2-word packets → grant order 0,1,3,0,1,3; one idle cycle between packets.
- **Backpressure**: toggle `src_ready_i` every cycle during a 6-word packet → each word transfers exactly once; `snk_ready_o[grant]` mirrors `src_ready_i`; other readies stay 0.
- **Stray flush**: source 1 presents valid without SOP while in IDLE → its `snk_ready_o` is high and no output valid appears. A single-word packet (SOP+EOP) from source 1 is then granted and forwarded.
- **Async reset mid-packet**: drop `rstn_i` after word 2 of 5 → all outputs are 0 before the next edge. After release, source 0 wins first.
- **Length guard** (macro defined, MAX_PKT_LEN=8): send a 12-word packet → 8 words are output with forced EOP on word 8; words 9–12 are accepted and discarded; the next packet is granted normally.
